// File: rtl/bram_rev_pkg.sv
// Shared types for the BRAM block-reorder engine.
package bram_rev_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {MODE_COPY, MODE_REV, MODE_BLKREV, MODE_RSVD} mode_t;
  localparam int MAX_RD_LAT = 4;
endpackage

// File: rtl/bram_rev_if.sv
// Source-read / destination-write BRAM port pair driven by the reorder engine.
interface bram_rev_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
);
  logic              src_en;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_rdata;
  logic              dst_we;
  logic [ADDR_W-1:0] dst_addr;
  logic [DATA_W-1:0] dst_wdata;

  modport master (output src_en, src_addr, dst_we, dst_addr, dst_wdata, input src_rdata);
  modport slave  (input src_en, src_addr, dst_we, dst_addr, dst_wdata, output src_rdata);
endinterface

// File: rtl/bram_rev_addr_pipe.sv
// Maps a source index to its destination address and delays it to line up
// with the source BRAM read data.
module bram_rev_addr_pipe
  import bram_rev_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_vld,
  input  logic [ADDR_W-1:0] idx,
  input  mode_t             mode,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] blk_mask,
  output logic              out_vld,
  output logic [ADDR_W-1:0] out_addr,
  output logic              drained
);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [RD_LAT-1:0]             vld_pipe;
  logic [RD_LAT-1:0][ADDR_W-1:0] addr_pipe;
  logic [ADDR_W-1:0]             d;

  always_comb begin
    case (mode)
      MODE_REV:    d = len - idx - ONE;
      MODE_BLKREV: d = (idx & ~blk_mask) | (blk_mask - (idx & blk_mask));
      default:     d = idx;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[0]  <= in_vld;
      addr_pipe[0] <= d;
      for (int k = 1; k < RD_LAT; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        addr_pipe[k] <= addr_pipe[k-1];
      end
    end
  end

  // Nothing left behind the output stage: the current write is the last one.
  always_comb begin
    drained = 1'b1;
    for (int k = 0; k < RD_LAT - 1; k++)
      if (vld_pipe[k]) drained = 1'b0;
  end

  assign out_vld  = vld_pipe[RD_LAT-1];
  assign out_addr = addr_pipe[RD_LAT-1];
endmodule

// File: rtl/bram_block_reverse.sv
// Streaming BRAM-to-BRAM copy engine: straight copy, full reversal or
// reversal inside power-of-two blocks, one word per cycle.
module bram_block_reverse
  import bram_rev_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [ADDR_W:0]             len,
  input  logic [$clog2(ADDR_W+1)-1:0] blk_log2,
  bram_rev_if.master                  bram,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [ADDR_W:0]             wr_count
);
  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_L = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  state_t            state, state_nx;
  mode_t             mode_q;
  logic [ADDR_W:0]   len_q, blk_mask_in;
  logic [ADDR_W-1:0] blk_mask, idx, pipe_addr;
  logic              req_err, issue, last_issue, pipe_vld, drained;

  // Blocks larger than the widest len make the remainder equal len itself.
  always_comb begin
    blk_mask_in = (int'(blk_log2) > ADDR_W) ? '1 : (ONE_L << blk_log2) - ONE_L;
    req_err     = (len > DEPTH) || (mode_t'(mode) == MODE_RSVD) ||
                  ((mode_t'(mode) == MODE_BLKREV) && ((len & blk_mask_in) != '0));
  end

  assign issue      = (state == RUN);
  assign last_issue = (({1'b0, idx} + ONE_L) == len_q);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = (req_err || len == '0) ? DONE : RUN;
      RUN:     if (last_issue) state_nx = DRAIN;
      DRAIN:   if (drained) state_nx = DONE;
      DONE:    if (!start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mode_q   <= MODE_COPY;
      len_q    <= '0;
      blk_mask <= '0;
      idx      <= '0;
      err      <= 1'b0;
      wr_count <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          mode_q   <= mode_t'(mode);
          len_q    <= len;
          blk_mask <= blk_mask_in[ADDR_W-1:0];
          idx      <= '0;
          err      <= req_err;
          wr_count <= '0;
        end
        RUN:     idx <= idx + ONE_A;
        default: ;
      endcase
      if (pipe_vld) wr_count <= wr_count + ONE_L;
    end
  end

  bram_rev_addr_pipe #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_vld   (issue),
    .idx      (idx),
    .mode     (mode_q),
    .len      (len_q[ADDR_W-1:0]),
    .blk_mask (blk_mask),
    .out_vld  (pipe_vld),
    .out_addr (pipe_addr),
    .drained  (drained)
  );

  assign bram.src_en    = issue;
  assign bram.src_addr  = idx;
  assign bram.dst_we    = pipe_vld;
  assign bram.dst_addr  = pipe_addr;
  assign bram.dst_wdata = pipe_vld ? bram.src_rdata : '0;
  assign busy           = (state == RUN) || (state == DRAIN);
  assign done           = (state == DONE);
endmodule

// File: tb/tb_bram_block_reverse.sv
// Bench for bram_block_reverse: two engines (read latency 1 and 3) share one
// control stream and are checked against an address-mapping reference model.
module tb_bram_block_reverse;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BW     = $clog2(ADDR_W + 1);
  localparam int NDUT   = 2;
  localparam logic [DATA_W-1:0] EMPTY = 32'hFFFF_FFFF;

  typedef struct packed {
    int done_cyc;
    int n_wr;
    int wr_count;
    int err;
    int first_we;
    int last_we;
    int n_rd;
    int rd_bad;
    int mem_bad;
  } xfer_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        mode = '0;
  logic [ADDR_W:0]   len = '0;
  logic [BW-1:0]     blk_log2 = '0;

  logic              src_en [NDUT];
  logic              dst_we [NDUT];
  logic              busy [NDUT];
  logic              done [NDUT];
  logic              err [NDUT];
  logic [ADDR_W-1:0] src_addr [NDUT];
  logic [ADDR_W-1:0] dst_addr [NDUT];
  logic [DATA_W-1:0] dst_wdata [NDUT];
  logic [ADDR_W:0]   wr_count [NDUT];

  int errors = 0;
  int checks = 0;
  int cyc;
  xfer_t obs [NDUT];
  xfer_t want [NDUT];
  logic [DATA_W-1:0] dst_mem [NDUT][DEPTH];
  logic [DATA_W-1:0] exp_mem [DEPTH];

  always #5 clk = ~clk;

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  for (genvar u = 0; u < NDUT; u++) begin : g_dut
    localparam int L = (u == 0) ? 1 : 3;
    bram_rev_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    logic [L-1:0]      en_d = '0;
    logic [ADDR_W-1:0] a_d [L];

    // Source BRAM holding word k = k, data valid L cycles after the read.
    always @(posedge clk) begin
      en_d[0] <= bus.src_en;
      a_d[0]  <= bus.src_addr;
      for (int k = 1; k < L; k++) begin
        en_d[k] <= en_d[k-1];
        a_d[k]  <= a_d[k-1];
      end
    end
    assign bus.src_rdata = en_d[L-1] ? DATA_W'(a_d[L-1]) : 32'hDEAD_BEEF;

    bram_block_reverse #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(L)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .mode     (mode),
      .len      (len),
      .blk_log2 (blk_log2),
      .bram     (bus),
      .busy     (busy[u]),
      .done     (done[u]),
      .err      (err[u]),
      .wr_count (wr_count[u])
    );

    assign src_en[u]    = bus.src_en;
    assign src_addr[u]  = bus.src_addr;
    assign dst_we[u]    = bus.dst_we;
    assign dst_addr[u]  = bus.dst_addr;
    assign dst_wdata[u] = bus.dst_wdata;
  end

  // Reference: destination index for source index i, from the mode rules.
  function automatic int map_addr(input int m, input int n, input int b, input int i);
    int bs;
    bs = 1 << b;
    case (m)
      1:       return n - 1 - i;
      2:       return (i / bs) * bs + (bs - 1 - (i % bs));
      default: return i;
    endcase
  endfunction

  task automatic model(input int m, input int n, input int b);
    int e, nw;
    e  = (n > DEPTH || m == 3 || (m == 2 && (n % (1 << b)) != 0)) ? 1 : 0;
    nw = e ? 0 : n;
    for (int j = 0; j < DEPTH; j++) exp_mem[j] = EMPTY;
    for (int i = 0; i < nw; i++) exp_mem[map_addr(m, n, b, i)] = DATA_W'(i);
    for (int u = 0; u < NDUT; u++) begin
      want[u]          = '0;
      want[u].done_cyc = (nw == 0) ? 1 : nw + lat_of(u) + 1;
      want[u].n_wr     = nw;
      want[u].wr_count = nw;
      want[u].err      = e;
      want[u].first_we = (nw == 0) ? -1 : 1 + lat_of(u);
      want[u].last_we  = (nw == 0) ? -1 : nw + lat_of(u);
      want[u].n_rd     = nw;
    end
  endtask

  // Starts a request and records both engines until both report done.
  task automatic run_xfer(input int m, input int n, input int b);
    model(m, n, b);
    for (int u = 0; u < NDUT; u++) begin
      obs[u]          = '0;
      obs[u].done_cyc = -1;
      obs[u].first_we = -1;
      obs[u].last_we  = -1;
      for (int j = 0; j < DEPTH; j++) dst_mem[u][j] = EMPTY;
    end
    @(negedge clk);
    start    = 1'b1;
    mode     = 2'(m);
    len      = (ADDR_W+1)'(n);
    blk_log2 = BW'(b);
    cyc = 0;
    while (!(done[0] && done[1]) && cyc < n + 20) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int u = 0; u < NDUT; u++) begin
        if (src_en[u]) begin
          if (int'(src_addr[u]) != obs[u].n_rd) obs[u].rd_bad++;
          obs[u].n_rd++;
        end
        if (dst_we[u]) begin
          dst_mem[u][dst_addr[u]] = dst_wdata[u];
          obs[u].n_wr++;
          if (obs[u].first_we < 0) obs[u].first_we = cyc;
          obs[u].last_we = cyc;
        end
        if (done[u] && obs[u].done_cyc < 0) obs[u].done_cyc = cyc;
      end
    end
    checks++;
    if (!(done[0] && done[1])) begin
      errors++;
      $display("FAIL xfer_timeout m=%0d n=%0d got done=%b%b want 11", m, n, done[0], done[1]);
    end
    for (int u = 0; u < NDUT; u++) begin
      obs[u].err      = int'(err[u]);
      obs[u].wr_count = int'(wr_count[u]);
      for (int j = 0; j < DEPTH; j++)
        if (dst_mem[u][j] !== exp_mem[j]) obs[u].mem_bad++;
    end
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < NDUT; u++) begin
      checks++;
      if ({src_en[u], src_addr[u], dst_we[u], dst_addr[u], dst_wdata[u], busy[u], done[u],
           err[u], wr_count[u]} !== '0) begin
        errors++;
        $display("FAIL reset_values lat=%0d got %h want 0", lat_of(u),
                 {src_en[u], src_addr[u], dst_we[u], dst_addr[u], dst_wdata[u], busy[u],
                  done[u], err[u], wr_count[u]});
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reverse_full();
    int bad;
    run_xfer(1, DEPTH, 0);
    for (int u = 0; u < NDUT; u++) begin
      checks++;
      if (obs[u] !== want[u]) begin
        errors++;
        $display("FAIL reverse lat=%0d got %p want %p", lat_of(u), obs[u], want[u]);
      end
      bad = 0;
      for (int j = 0; j < DEPTH; j++)
        if (dst_mem[u][j] !== DATA_W'(DEPTH - 1 - j)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL reverse_words lat=%0d got %0d wrong words want 0", lat_of(u), bad);
      end
    end
    release_start();
  endtask

  task automatic test_block_reverse();
    run_xfer(2, 16, 2);
    for (int u = 0; u < NDUT; u++) begin
      checks++;
      if (obs[u] !== want[u]) begin
        errors++;
        $display("FAIL blk_reverse lat=%0d got %p want %p", lat_of(u), obs[u], want[u]);
      end
      checks++;
      if (dst_mem[u][5] !== 32'd6) begin
        errors++;
        $display("FAIL blk_reverse_word5 lat=%0d got %0d want 6", lat_of(u), dst_mem[u][5]);
      end
    end
    release_start();
  endtask

  task automatic test_single();
    run_xfer(0, 1, 0);
    for (int u = 0; u < NDUT; u++) begin
      checks++;
      if (obs[u] !== want[u]) begin
        errors++;
        $display("FAIL single lat=%0d got %p want %p", lat_of(u), obs[u], want[u]);
      end
    end
    release_start();
  endtask

  task automatic test_errors();
    int tm [3] = '{2, 1, 0};
    int tn [3] = '{10, DEPTH + 1, 0};
    int tb [3] = '{2, 0, 0};
    for (int t = 0; t < 3; t++) begin
      run_xfer(tm[t], tn[t], tb[t]);
      for (int u = 0; u < NDUT; u++) begin
        checks++;
        if (obs[u] !== want[u]) begin
          errors++;
          $display("FAIL err_case%0d lat=%0d got %p want %p", t, lat_of(u), obs[u], want[u]);
        end
      end
      release_start();
    end
  endtask

  task automatic test_handshake();
    run_xfer(0, 8, 0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      for (int u = 0; u < NDUT; u++) begin
        checks++;
        if (done[u] !== 1'b1) begin
          errors++;
          $display("FAIL hold_done c=%0d lat=%0d got %b want 1", c, lat_of(u), done[u]);
        end
      end
    end
    release_start();
    for (int u = 0; u < NDUT; u++) begin
      checks++;
      if (done[u] !== 1'b0) begin
        errors++;
        $display("FAIL done_fall lat=%0d got %b want 0", lat_of(u), done[u]);
      end
    end
    run_xfer(0, 32, 0);
    for (int u = 0; u < NDUT; u++) begin
      checks++;
      if (obs[u] !== want[u]) begin
        errors++;
        $display("FAIL back_to_back lat=%0d got %p want %p", lat_of(u), obs[u], want[u]);
      end
    end
    release_start();
  endtask

  task automatic test_random();
    int m, b, n;
    for (int it = 0; it < 8; it++) begin
      m = $urandom_range(0, 3);
      b = $urandom_range(0, 6);
      case ($urandom_range(0, 4))
        0:       n = $urandom_range(0, 300);
        4:       n = $urandom_range(DEPTH + 1, 2 * DEPTH - 1);
        default: n = (1 << b) * $urandom_range(0, 12);
      endcase
      run_xfer(m, n, b);
      for (int u = 0; u < NDUT; u++) begin
        checks++;
        if (obs[u] !== want[u]) begin
          errors++;
          $display("FAIL random%0d m=%0d n=%0d b=%0d lat=%0d got %p want %p",
                   it, m, n, b, lat_of(u), obs[u], want[u]);
        end
      end
      release_start();
    end
  endtask

  task automatic test_reset_mid_run();
    int stray;
    @(negedge clk);
    start    = 1'b1;
    mode     = 2'd1;
    len      = (ADDR_W+1)'(DEPTH);
    blk_log2 = '0;
    repeat (101) @(posedge clk);
    #1;
    for (int u = 0; u < NDUT; u++) begin
      checks++;
      if (src_en[u] !== 1'b1 || src_addr[u] !== ADDR_W'(100)) begin
        errors++;
        $display("FAIL mid_run_addr lat=%0d got en=%b addr=%0d want en=1 addr=100",
                 lat_of(u), src_en[u], src_addr[u]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    for (int u = 0; u < NDUT; u++) begin
      checks++;
      if ({src_en[u], src_addr[u], dst_we[u], dst_addr[u], dst_wdata[u], busy[u], done[u],
           err[u], wr_count[u]} !== '0) begin
        errors++;
        $display("FAIL mid_reset_values lat=%0d got %h want 0", lat_of(u),
                 {src_en[u], src_addr[u], dst_we[u], dst_addr[u], dst_wdata[u], busy[u],
                  done[u], err[u], wr_count[u]});
      end
    end
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      for (int u = 0; u < NDUT; u++) if (dst_we[u] || src_en[u]) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL after_reset_activity got %0d want 0", stray);
    end
    run_xfer(1, 256, 0);
    for (int u = 0; u < NDUT; u++) begin
      checks++;
      if (obs[u] !== want[u]) begin
        errors++;
        $display("FAIL after_reset_xfer lat=%0d got %p want %p", lat_of(u), obs[u], want[u]);
      end
    end
    release_start();
  endtask

  initial begin
    test_reset();
    test_reverse_full();
    test_block_reverse();
    test_single();
    test_errors();
    test_handshake();
    test_random();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
